// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Shortest legal bit period; anything smaller is clamped at accept.
  localparam int MIN_DIV = 2;

  // Parity bit that makes XOR(data, bit) = 0 (even) or 1 (odd).
  function automatic logic par_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake plus per-frame divisor between producer and transmitter.
interface uart_tx_sched_if #(
  parameter int DIV_W = 16
);
  logic [DIV_W-1:0] divisor;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output divisor, output tx_data, output tx_valid, input tx_ready);
  modport slave  (input divisor, input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sched_baud_tick_gen.sv
// Restartable bit-period counter: clear zeroes the count and loads the
// clamped divisor, so bit boundaries line up with the frame start.
module baud_tick_gen
  import uart_tx_sched_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick
);
  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // Count 0..div-1 while enabled; wrap on tick so the next bit starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= MIN_D;
      cnt   <= '0;
    end else if (clear) begin
      div_q <= (div_in < MIN_D) ? MIN_D : div_in;
      cnt   <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

  assign tick = en && (cnt == div_q - DIV_W'(1));

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit controller: accepts a byte, then sequences start, 8 data
// bits LSB first, optional parity and stop bit(s) on a registered tx line.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PAR_NONE
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_sched_if.slave   bus,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);
  state_e     state;
  logic [7:0] shreg;
  logic       par_q;
  logic [2:0] bit_idx;
  logic       tick;
  logic       xfer;

  assign xfer = bus.tx_valid & bus.tx_ready;

  // busy spans exactly the non-idle states, so it doubles as counter enable.
  baud_tick_gen #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (xfer),
    .en     (busy),
    .div_in (bus.divisor),
    .tick   (tick)
  );

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      par_q        <= 1'b0;
      bit_idx      <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      bus.tx_ready <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (xfer) begin
          shreg        <= bus.tx_data;
          par_q        <= par_bit(bus.tx_data, PARITY);
          bit_idx      <= '0;
          tx           <= 1'b0;
          busy         <= 1'b1;
          bus.tx_ready <= 1'b0;
          state        <= S_START;
        end
        S_START: if (tick) begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
          state <= S_DATA;
        end
        S_DATA: if (tick) begin
          if (bit_idx != 3'd7) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_idx <= '0;
            if (PARITY != PAR_NONE) begin
              tx    <= par_q;
              state <= S_PARITY;
            end else begin
              tx    <= 1'b1;
              state <= S_STOP;
            end
          end
        end
        S_PARITY: if (tick) begin
          tx    <= 1'b1;
          state <= S_STOP;
        end
        S_STOP: if (tick) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx      <= '0;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
            frame_done   <= 1'b1;
            state        <= S_IDLE;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: begin
          tx           <= 1'b1;
          busy         <= 1'b0;
          bus.tx_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: four configurations share one stimulus stream and
// are compared every cycle against a frame-timeline model.
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] divisor = 16'd4;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic [N-1:0]  tx_o, busy_o, fd_o, rdy_o;

  int  chk = 0;
  int  err = 0;
  int  phase = 0;
  bit  timeout_hit = 1'b0;
  bit  to_seen = 1'b0;

  always #5 clk = ~clk;

  // 0: no parity/1 stop, 1: even, 2: odd, 3: no parity/2 stops
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_sched_if #(.DIV_W(DW)) bus ();
    assign bus.divisor  = divisor;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign rdy_o[g]     = bus.tx_ready;
    uart_tx_sched #(
      .DIV_W(DW),
      .STOP_BITS(g == 3 ? 2 : 1),
      .PARITY(g == 1 ? 1 : (g == 2 ? 2 : 0))
    ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave),
      .tx(tx_o[g]), .busy(busy_o[g]), .frame_done(fd_o[g])
    );
  end

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction

  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, i, got, exp, $time);
    end
  endtask

  // Model: k = cycles since the transfer edge (-1 = none since reset).
  // Cycles 1..L carry frame bit (k-1)/div; cycle L+1 is the done cycle.
  int         k  [N] = '{default: -1};
  int         len[N] = '{default: 0};
  int         dv [N] = '{default: 2};
  logic [11:0] fr[N];
  logic [9:0] obs = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic e_tx, e_busy, e_rdy, e_fd;
      int   nb;
      if (!reset_n) k[i] = -1;
      else if (k[i] >= 0) k[i]++;
      if (k[i] >= 1 && k[i] <= len[i]) begin
        e_tx = fr[i][(k[i] - 1) / dv[i]]; e_busy = 1'b1; e_rdy = 1'b0; e_fd = 1'b0;
      end else begin
        e_tx = 1'b1; e_busy = 1'b0; e_rdy = 1'b1; e_fd = (k[i] >= 1 && k[i] == len[i] + 1);
      end
      check("tx", i, tx_o[i], e_tx);
      check("busy", i, busy_o[i], e_busy);
      check("tx_ready", i, rdy_o[i], e_rdy);
      check("frame_done", i, fd_o[i], e_fd);

      // hand-computed expectations for the directed frames
      if (phase == 2 && i == 0 && k[i] >= 1 && k[i] <= 37 && (k[i] - 1) % 4 == 0)
        obs[(k[i] - 1) / 4] = tx_o[0];
      if (phase == 2 && i == 0 && k[i] == 41) begin
        check("a5_bits", 0, obs, 10'b1101001010);
        check("a5_done41", 0, fd_o[0], 1);
        check("a5_ready41", 0, rdy_o[0], 1);
      end
      if (phase == 3 && i == 1 && k[i] == 37) check("par_even_bit", 1, tx_o[1], 1);
      if (phase == 3 && i == 2 && k[i] == 37) check("par_odd_bit", 2, tx_o[2], 0);
      if (phase == 3 && i == 1 && k[i] == 45) check("par_done45", 1, fd_o[1], 1);
      if (phase == 4 && i == 0 && k[i] == 41) check("b2b_gap_high", 0, tx_o[0], 1);
      if (phase == 5 && i == 0 && k[i] == 21) check("div0_done21", 0, fd_o[0], 1);
      if (phase == 6 && i == 0 && k[i] == 41) check("div4_kept", 0, fd_o[0], 1);
      if (phase == 7 && i == 0 && k[i] == 81) check("div8_next", 0, fd_o[0], 1);
      if (phase == 8 && !reset_n) begin
        check("rst_tx", i, tx_o[i], 1);
        check("rst_busy", i, busy_o[i], 0);
      end
      if (phase == 9 && i == 0 && k[i] == 41) check("post_rst_done", 0, fd_o[0], 1);
      if (phase == 10 && i == 3) begin
        if (k[i] == 3906) check("sb2_d7", 3, tx_o[3], 0);
        if (k[i] == 3907) check("sb2_stop_start", 3, tx_o[3], 1);
        if (k[i] == 4774) check("sb2_stop_end", 3, tx_o[3], 1);
        if (k[i] == 4775) check("sb2_done4775", 3, fd_o[3], 1);
      end

      // transfer at the coming edge: build this instance's frame
      if (reset_n && e_rdy && tx_valid) begin
        fr[i]      = '1;
        fr[i][0]   = 1'b0;
        fr[i][8:1] = tx_data;
        nb = 9;
        if (par_of(i) != 0) begin
          fr[i][9] = (par_of(i) == 1) ? ^tx_data : ~^tx_data;
          nb++;
        end
        nb     += sb_of(i);
        dv[i]   = (divisor < 16'd2) ? 2 : int'(divisor);
        len[i]  = nb * dv[i];
        k[i]    = 0;
      end
    end
    if (timeout_hit && !to_seen) begin
      to_seen = 1'b1;
      check("wait_idle_timeout", 0, 1, 0);
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!((&rdy_o) && !(|busy_o)) && c < 8000) begin
      tick_n(1);
      c++;
    end
    if (c >= 8000) timeout_hit = 1'b1;
  endtask

  task automatic send(input int ph, input logic [7:0] d, input logic [DW-1:0] dvs);
    phase    = ph;
    tx_data  = d;
    divisor  = dvs;
    tx_valid = 1'b1;
    tick_n(1);
    tx_valid = 1'b0;
    wait_idle();
    tick_n(2);
  endtask

  initial begin
    phase = 1;
    tick_n(3);
    reset_n = 1'b1;
    tick_n(2);

    send(2, 8'hA5, 16'd4);
    send(3, 8'h07, 16'd4);

    // held valid: each instance takes 0xAA right after its 0x55 frame
    phase = 4; tx_data = 8'h55; divisor = 16'd4; tx_valid = 1'b1;
    tick_n(1);
    tx_data = 8'hAA;
    tick_n(46);
    tx_valid = 1'b0;
    wait_idle();
    tick_n(2);

    send(5, 8'($urandom), 16'd0);

    // divisor changes mid-frame only affect the next frame
    phase = 6; tx_data = 8'($urandom); divisor = 16'd4; tx_valid = 1'b1;
    tick_n(1);
    tx_valid = 1'b0;
    tick_n(10);
    divisor = 16'd8;
    tx_data = 8'($urandom);
    wait_idle();
    send(7, 8'($urandom), 16'd8);

    // reset during data bit 3, asserted between clock edges
    phase = 8; tx_data = 8'h96; divisor = 16'd4; tx_valid = 1'b1;
    tick_n(1);
    tx_valid = 1'b0;
    tick_n(17);
    #1 reset_n = 1'b0;
    tick_n(3);
    reset_n = 1'b1;
    tick_n(2);

    send(9, 8'h3C, 16'd4);
    send(10, 8'h3C, 16'd434);

    phase = 11;
    repeat (3000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      divisor  = 16'($urandom_range(0, 9));
      tick_n(1);
    end
    tx_valid = 1'b0;
    wait_idle();
    tick_n(3);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout reached t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
